// File: rtl/led_colour_seq.sv
// Colour-code sequencer: steps a WIDTH-bit colour through MIN_VAL..MAX_VAL with wrap,
// direction, load and out-of-range recovery. Define LED_SEQ_AUTO_EN to add auto_en stepping.
module led_colour_seq #(
  parameter int WIDTH       = 3,
  parameter int MIN_VAL     = 1,
  parameter int MAX_VAL     = 6,
  parameter int EDGE_MODE   = 0,
  parameter int AUTO_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef LED_SEQ_AUTO_EN
  input  logic             auto_en,
`endif
  output logic [WIDTH-1:0] colour,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_colour;
  logic [WIDTH-1:0] w_colour_next;
  logic             r_wrap;
  logic             w_wrap_next;
  logic             r_button_q;
  logic             w_out_of_range;
  logic             w_btn_req;
  logic             w_step;

  // Edge mode needs the previous button level; it is tracked in both modes.
  assign w_btn_req      = (EDGE_MODE != 0) ? (button & ~r_button_q) : button;
  assign w_out_of_range = (r_colour < MIN_C) || (r_colour > MAX_C);

`ifdef LED_SEQ_AUTO_EN
  localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(AUTO_PERIOD - 1);

  logic [CW-1:0] r_auto_cnt;
  logic          w_auto_req;

  assign w_auto_req = auto_en && (r_auto_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst || load || !auto_en) begin
      r_auto_cnt <= '0;
    end else if (w_auto_req) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + CW'(1);
    end
  end

  assign w_step = w_btn_req | w_auto_req;
`else
  assign w_step = w_btn_req;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_colour   <= '0;
      r_wrap     <= 1'b0;
      r_button_q <= 1'b0;
    end else begin
      r_colour   <= w_colour_next;
      r_wrap     <= w_wrap_next;
      r_button_q <= button;
    end
  end

  // Next-state: load beats recovery beats step; the range check guards the +/-1.
  always_comb begin
    w_colour_next = r_colour;
    w_wrap_next   = 1'b0;
    if (load) begin
      w_colour_next = load_val;
    end else if (w_out_of_range) begin
      w_colour_next = MIN_C;
    end else if (w_step) begin
      if (!dir) begin
        if (r_colour == MAX_C) begin
          w_colour_next = MIN_C;
          w_wrap_next   = 1'b1;
        end else begin
          w_colour_next = r_colour + WIDTH'(1);
        end
      end else begin
        if (r_colour == MIN_C) begin
          w_colour_next = MAX_C;
          w_wrap_next   = 1'b1;
        end else begin
          w_colour_next = r_colour - WIDTH'(1);
        end
      end
    end
  end

  // Outputs
  always_comb begin
    colour = r_colour;
    wrap   = r_wrap;
  end

endmodule

// File: tb/tb_led_colour_seq.sv
// Scoreboard bench for led_colour_seq: level, edge and single-value-range instances
// share stimulus; expected colour/wrap are queued per cycle and checked by a monitor.
module tb_led_colour_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       button = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] c0, c1, c2;
  logic       w0, w1, w2;
`ifdef LED_SEQ_AUTO_EN
  logic       auto_en = 1'b0;
`endif

  always #5 clk = ~clk;

  led_colour_seq #(.WIDTH(3), .MIN_VAL(1), .MAX_VAL(6), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst(rst), .button(button), .dir(dir), .load(load), .load_val(load_val),
`ifdef LED_SEQ_AUTO_EN
    .auto_en(auto_en),
`endif
    .colour(c0), .wrap(w0));

  led_colour_seq #(.WIDTH(3), .MIN_VAL(1), .MAX_VAL(6), .EDGE_MODE(1)) u_edge (
    .clk(clk), .rst(rst), .button(button), .dir(dir), .load(load), .load_val(load_val),
`ifdef LED_SEQ_AUTO_EN
    .auto_en(auto_en),
`endif
    .colour(c1), .wrap(w1));

  led_colour_seq #(.WIDTH(3), .MIN_VAL(3), .MAX_VAL(3), .EDGE_MODE(0)) u_one (
    .clk(clk), .rst(rst), .button(button), .dir(dir), .load(load), .load_val(load_val),
`ifdef LED_SEQ_AUTO_EN
    .auto_en(auto_en),
`endif
    .colour(c2), .wrap(w2));

  typedef struct {
    int         dut;
    logic [2:0] c;
    logic       w;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor: outputs are stable between rising edges, so compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t       e;
        logic [2:0] ac;
        logic       aw;
        e = sb.pop_front();
        case (e.dut)
          0:       begin ac = c0; aw = w0; end
          1:       begin ac = c1; aw = w1; end
          default: begin ac = c2; aw = w2; end
        endcase
        n_vec++;
        if (ac !== e.c || aw !== e.w) begin
          n_err++;
          $display("FAIL %s dut%0d: colour=%0d wrap=%0d, expected colour=%0d wrap=%0d",
                   e.name, e.dut, ac, aw, e.c, e.w);
        end else begin
          $display("ok   %s dut%0d: colour=%0d wrap=%0d", e.name, e.dut, ac, aw);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic b, input logic d,
                     input logic l, input logic [2:0] v);
    @(negedge clk);
    rst = r; button = b; dir = d; load = l; load_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int dut, input logic [2:0] c, input logic w, input string nm);
    exp_t e;
    e.dut = dut; e.c = c; e.w = w; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    logic [2:0] up_c [8];
    logic       up_w [8];
    logic [2:0] tog_c [6];
    logic       tog_w [6];
    up_c = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
    up_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tog_c = '{3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd1};
    tog_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    cyc(1, 0, 0, 0, 3'd0);
    expect_out(0, 3'd0, 1'b0, "reset");
    expect_out(1, 3'd0, 1'b0, "reset");
    expect_out(2, 3'd0, 1'b0, "reset");

    // Level up-count with recovery from 0 and wrap 6->1
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 3'd0);
      expect_out(0, up_c[i], up_w[i], "up_level");
      expect_out(1, 3'd1, 1'b0, "edge_held");
      expect_out(2, 3'd3, (i > 0) ? 1'b1 : 1'b0, "min_eq_max");
    end

    // Down-count from 2 with wrap 1->6, then hold
    cyc(0, 1, 1, 0, 3'd0); expect_out(0, 3'd1, 1'b0, "down");
    cyc(0, 1, 1, 0, 3'd0); expect_out(0, 3'd6, 1'b1, "down_wrap");
    cyc(0, 1, 1, 0, 3'd0); expect_out(0, 3'd5, 1'b0, "down");
    expect_out(2, 3'd3, 1'b1, "min_eq_max_down");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 3'd0);
      expect_out(0, 3'd5, 1'b0, "hold");
      expect_out(2, 3'd3, 1'b0, "hold_one");
    end

    // Out-of-range load, recovery discards the step, load beats button
    cyc(0, 0, 0, 1, 3'd7);
    expect_out(0, 3'd7, 1'b0, "load7");
    expect_out(1, 3'd7, 1'b0, "load7");
    expect_out(2, 3'd7, 1'b0, "load7");
    cyc(0, 1, 0, 0, 3'd0);
    expect_out(0, 3'd1, 1'b0, "recover");
    expect_out(1, 3'd1, 1'b0, "recover_edge");
    expect_out(2, 3'd3, 1'b0, "recover_one");
    cyc(0, 1, 0, 1, 3'd4);
    expect_out(0, 3'd4, 1'b0, "load_wins");
    expect_out(1, 3'd4, 1'b0, "load_wins");

    // Edge mode: held button gives one step, then toggles step once each
    cyc(0, 0, 0, 1, 3'd3);
    expect_out(1, 3'd3, 1'b0, "edge_load3");
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0, 3'd0);
      expect_out(1, 3'd4, 1'b0, "edge_hold_hi");
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, (i % 2 == 1) ? 1'b0 : 1'b1, 0, 0, 3'd0);
      // i=0 is still high from the hold above, so the sequence is hi,lo,hi,lo,hi,lo shifted
    end
    cyc(0, 0, 0, 1, 3'd3);
    expect_out(1, 3'd3, 1'b0, "edge_reload3");
    cyc(0, 1, 0, 0, 3'd0);
    expect_out(1, 3'd4, 1'b0, "edge_first");
    for (int i = 0; i < 6; i++) begin
      cyc(0, (i % 2 == 0) ? 1'b0 : 1'b1, 0, 0, 3'd0);
      expect_out(1, tog_c[i], tog_w[i], "edge_toggle");
    end

    // Reset mid-operation with button held
    cyc(0, 0, 0, 1, 3'd5);
    expect_out(0, 3'd5, 1'b0, "load5");
    cyc(1, 1, 0, 0, 3'd0);
    expect_out(0, 3'd0, 1'b0, "mid_reset");
    expect_out(1, 3'd0, 1'b0, "mid_reset");
    cyc(0, 1, 0, 0, 3'd0);
    expect_out(0, 3'd1, 1'b0, "post_reset");
    expect_out(1, 3'd1, 1'b0, "post_reset_edge");
    cyc(0, 1, 0, 0, 3'd0);
    expect_out(0, 3'd2, 1'b0, "post_reset");
    expect_out(1, 3'd1, 1'b0, "post_reset_edge_held");

    // Drain with a bounded wait
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
